// File: rtl/reg_wr_arbiter.sv
// -----------------------------------------------------------------------------
// reg_wr_arbiter
//   Shares the single register-file write port between two writeback
//   requesters (req0 = ALU writeback, req1 = load/memory writeback).
//   A round-robin grant with valid/ready handshake selects one requester per
//   cycle. The winner is captured into a one-entry output stage that drives the
//   register file write port. The stage drains every cycle, so a lone valid
//   request is never stalled.
//   The block also flags read-after-write hazards against two snooped read
//   pointers, provides bypass data, and keeps a saturating commit counter.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req0_valid/addr/data       requester 0 write request
//   req0_ready                 requester 0 granted this cycle (combinational)
//   req1_valid/addr/data       requester 1 write request
//   req1_ready                 requester 1 granted this cycle (combinational)
//   rd_addrA, rd_addrB         snooped register-file read pointers
//   rf_wr_en/addr, rf_dat_in   registered register-file write port
//   bypA_vld/data              stage holds a write to rd_addrA, and its data
//   bypB_vld/data              stage holds a write to rd_addrB, and its data
//   wr_count                   committed writes, saturating at all-ones
// -----------------------------------------------------------------------------
module reg_wr_arbiter #(
  parameter int DW = 8,
  parameter int AW = 3,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  input  logic [AW-1:0] rd_addrA,
  input  logic [AW-1:0] rd_addrB,
  output logic          rf_wr_en,
  output logic [AW-1:0] rf_wr_addr,
  output logic [DW-1:0] rf_dat_in,
  output logic          bypA_vld,
  output logic [DW-1:0] bypA_data,
  output logic          bypB_vld,
  output logic [DW-1:0] bypB_data,
  output logic [CW-1:0] wr_count
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  // Round-robin pointer: index of the requester granted on the last transfer.
  logic          rr_last_q, rr_last_d;
  logic          wr_en_q,   wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic [CW-1:0] cnt_q,     cnt_d;

  logic          gnt0_s, gnt1_s;
  logic          xfer_s;

  // Grant selection; no grants are issued while reset is asserted.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (!rst_n) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else begin
      case ({req1_valid, req0_valid})
        2'b01:   gnt0_s = 1'b1;
        2'b10:   gnt1_s = 1'b1;
        // Contention: favour the requester that did not win last time.
        2'b11: begin
          if (rr_last_q) begin
            gnt0_s = 1'b1;
          end else begin
            gnt1_s = 1'b1;
          end
        end
        default: begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
      endcase
    end
  end

  assign req0_ready = gnt0_s;
  assign req1_ready = gnt1_s;
  // A grant is only given to a valid requester, so a grant is a transfer.
  assign xfer_s     = gnt0_s | gnt1_s;

  // Next-state for the pointer, the output stage and the commit counter.
  always_comb begin
    rr_last_d = rr_last_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    cnt_d     = cnt_q;

    if (xfer_s) begin
      wr_en_d = 1'b1;
      if (gnt1_s) begin
        rr_last_d = 1'b1;
        wr_addr_d = req1_addr;
        wr_data_d = req1_data;
      end else begin
        rr_last_d = 1'b0;
        wr_addr_d = req0_addr;
        wr_data_d = req0_data;
      end
    end else begin
      // Idle: address/data hold so the write port stays quiet.
      wr_en_d = 1'b0;
    end

    // The register file commits on every edge where the stage is enabled.
    if (wr_en_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers; reset drops any write sitting in the stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q <= 1'b1;
      wr_en_q   <= 1'b0;
      wr_addr_q <= {AW{1'b0}};
      wr_data_q <= {DW{1'b0}};
      cnt_q     <= {CW{1'b0}};
    end else begin
      rr_last_q <= rr_last_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign rf_wr_en   = wr_en_q;
  assign rf_wr_addr = wr_addr_q;
  assign rf_dat_in  = wr_data_q;
  assign wr_count   = cnt_q;

  // Hazard/bypass: a pending write matching a read pointer forwards its data.
  assign bypA_vld  = wr_en_q && (wr_addr_q == rd_addrA);
  assign bypB_vld  = wr_en_q && (wr_addr_q == rd_addrB);
  assign bypA_data = bypA_vld ? wr_data_q : {DW{1'b0}};
  assign bypB_data = bypB_vld ? wr_data_q : {DW{1'b0}};

endmodule

// File: tb/tb_reg_wr_arbiter.sv
module tb_reg_wr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0;
  logic [2:0] req0_addr = 3'd0;
  logic [7:0] req0_data = 8'd0;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [2:0] req1_addr = 3'd0;
  logic [7:0] req1_data = 8'd0;
  logic       req1_ready;
  logic [2:0] rd_addrA = 3'd0;
  logic [2:0] rd_addrB = 3'd0;
  logic       rf_wr_en;
  logic [2:0] rf_wr_addr;
  logic [7:0] rf_dat_in;
  logic       bypA_vld, bypB_vld;
  logic [7:0] bypA_data, bypB_data;
  logic [15:0] wr_count;

  // Narrow-counter instance sharing the same stimulus.
  logic       s_ready0, s_ready1, s_en, s_bva, s_bvb;
  logic [2:0] s_addr;
  logic [7:0] s_dat, s_bda, s_bdb;
  logic [3:0] s_count;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] rf_model [8];

  always #5 clk = ~clk;

  reg_wr_arbiter #(.DW(8), .AW(3), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_dat_in(rf_dat_in),
    .bypA_vld(bypA_vld), .bypA_data(bypA_data), .bypB_vld(bypB_vld), .bypB_data(bypB_data),
    .wr_count(wr_count)
  );

  reg_wr_arbiter #(.DW(8), .AW(3), .CW(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(s_ready0),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(s_ready1),
    .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
    .rf_wr_en(s_en), .rf_wr_addr(s_addr), .rf_dat_in(s_dat),
    .bypA_vld(s_bva), .bypA_data(s_bda), .bypB_vld(s_bvb), .bypB_data(s_bdb),
    .wr_count(s_count)
  );

  // Reference register file fed by the DUT write port.
  always @(posedge clk) begin
    if (rf_wr_en) rf_model[rf_wr_addr] <= rf_dat_in;
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    n_cmp++; if (rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got=%b exp=0", rf_wr_en); end
    n_cmp++; if (rf_wr_addr !== 3'd0) begin n_fail++; $display("FAIL reset_wr_addr got=%0d exp=0", rf_wr_addr); end
    n_cmp++; if (rf_dat_in !== 8'd0) begin n_fail++; $display("FAIL reset_dat_in got=%h exp=00", rf_dat_in); end
    n_cmp++; if (wr_count !== 16'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", wr_count); end
    n_cmp++; if ({req1_ready, req0_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got=%b exp=00", {req1_ready, req0_ready}); end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = 3'd3; req0_data = 8'h5A;
    #1;
    n_cmp++; if ({req1_ready, req0_ready} !== 2'b01) begin n_fail++; $display("FAIL single_ready got=%b exp=01", {req1_ready, req0_ready}); end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    n_cmp++; if ({rf_wr_en, rf_wr_addr, rf_dat_in} !== {1'b1, 3'd3, 8'h5A})
      begin n_fail++; $display("FAIL single_stage got=%b/%0d/%h exp=1/3/5a", rf_wr_en, rf_wr_addr, rf_dat_in); end
    @(posedge clk); #1;
    n_cmp++; if (wr_count !== 16'd1) begin n_fail++; $display("FAIL single_count got=%0d exp=1", wr_count); end
    n_cmp++; if (rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL single_idle_en got=%b exp=0", rf_wr_en); end
    n_cmp++; if (rf_wr_addr !== 3'd3) begin n_fail++; $display("FAIL single_hold_addr got=%0d exp=3", rf_wr_addr); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_rdy [4];
    logic [2:0] exp_addr [4];
    logic [7:0] exp_dat [4];
    exp_rdy  = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_addr = '{3'd1, 3'd2, 3'd1, 3'd2};
    exp_dat  = '{8'h11, 8'h22, 8'h11, 8'h22};
    apply_reset();
    req0_valid = 1'b1; req0_addr = 3'd1; req0_data = 8'h11;
    req1_valid = 1'b1; req1_addr = 3'd2; req1_data = 8'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if ({req1_ready, req0_ready} !== exp_rdy[i])
        begin n_fail++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, {req1_ready, req0_ready}, exp_rdy[i]); end
      @(posedge clk); #1;
      n_cmp++; if ({rf_wr_addr, rf_dat_in} !== {exp_addr[i], exp_dat[i]})
        begin n_fail++; $display("FAIL rr_stage[%0d] got=%0d/%h exp=%0d/%h", i, rf_wr_addr, rf_dat_in, exp_addr[i], exp_dat[i]); end
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_same_addr();
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = 3'd5; req0_data = 8'hAA;
    req1_valid = 1'b1; req1_addr = 3'd5; req1_data = 8'hBB;
    #1;
    n_cmp++; if ({req1_ready, req0_ready} !== 2'b01) begin n_fail++; $display("FAIL same_first_grant got=%b exp=01", {req1_ready, req0_ready}); end
    @(posedge clk); #1;
    n_cmp++; if ({rf_wr_en, rf_dat_in} !== {1'b1, 8'hAA}) begin n_fail++; $display("FAIL same_first_write got=%b/%h exp=1/aa", rf_wr_en, rf_dat_in); end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    n_cmp++; if ({req1_ready, req0_ready} !== 2'b10) begin n_fail++; $display("FAIL same_second_grant got=%b exp=10", {req1_ready, req0_ready}); end
    @(posedge clk); #1;
    n_cmp++; if ({rf_wr_en, rf_wr_addr, rf_dat_in} !== {1'b1, 3'd5, 8'hBB})
      begin n_fail++; $display("FAIL same_second_write got=%b/%0d/%h exp=1/5/bb", rf_wr_en, rf_wr_addr, rf_dat_in); end
    @(negedge clk);
    req1_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (rf_model[5] !== 8'hBB) begin n_fail++; $display("FAIL same_final_reg got=%h exp=bb", rf_model[5]); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = 3'd4; req0_data = 8'h3C;
    rd_addrA = 3'd4; rd_addrB = 3'd6;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    n_cmp++; if ({bypA_vld, bypA_data} !== {1'b1, 8'h3C}) begin n_fail++; $display("FAIL bypA_hit got=%b/%h exp=1/3c", bypA_vld, bypA_data); end
    n_cmp++; if ({bypB_vld, bypB_data} !== {1'b0, 8'h00}) begin n_fail++; $display("FAIL bypB_miss got=%b/%h exp=0/00", bypB_vld, bypB_data); end
    rd_addrB = 3'd4;
    #1;
    n_cmp++; if ({bypB_vld, bypB_data} !== {1'b1, 8'h3C}) begin n_fail++; $display("FAIL bypB_hit got=%b/%h exp=1/3c", bypB_vld, bypB_data); end
    @(posedge clk); #1;
    n_cmp++; if ({bypA_vld, bypA_data} !== {1'b0, 8'h00}) begin n_fail++; $display("FAIL bypA_idle got=%b/%h exp=0/00", bypA_vld, bypA_data); end
    rd_addrA = 3'd0; rd_addrB = 3'd0;
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = 3'd7; req0_data = 8'h77;
    @(posedge clk); #1;
    n_cmp++; if (rf_wr_en !== 1'b1) begin n_fail++; $display("FAIL mid_pre_en got=%b exp=1", rf_wr_en); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL mid_async_en got=%b exp=0", rf_wr_en); end
    n_cmp++; if (wr_count !== 16'd0) begin n_fail++; $display("FAIL mid_async_count got=%0d exp=0", wr_count); end
    n_cmp++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready_in_reset got=%b exp=0", req0_ready); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req0_addr = 3'd1; req0_data = 8'h01;
    req1_valid = 1'b1; req1_addr = 3'd2; req1_data = 8'h02;
    #1;
    n_cmp++; if ({req1_ready, req0_ready} !== 2'b01) begin n_fail++; $display("FAIL mid_post_grant got=%b exp=01", {req1_ready, req0_ready}); end
    n_cmp++; if (rf_model[7] !== 8'h00) begin n_fail++; $display("FAIL mid_dropped_write got=%h exp=00", rf_model[7]); end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int exp_small;
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      req0_valid = 1'b1;
      req0_addr  = 3'(i);
      req0_data  = 8'(i);
      @(posedge clk); #1;
      exp_small = (i > 15) ? 15 : i;
      n_cmp++; if ({rf_wr_en, rf_dat_in} !== {1'b1, 8'(i)}) begin n_fail++; $display("FAIL b2b_stage[%0d] got=%b/%h exp=1/%h", i, rf_wr_en, rf_dat_in, 8'(i)); end
      n_cmp++; if (wr_count !== 16'(i)) begin n_fail++; $display("FAIL b2b_count[%0d] got=%0d exp=%0d", i, wr_count, i); end
      n_cmp++; if (s_count !== 4'(exp_small)) begin n_fail++; $display("FAIL b2b_sat_count[%0d] got=%0d exp=%0d", i, s_count, exp_small); end
      @(negedge clk);
    end
    req0_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (wr_count !== 16'd20) begin n_fail++; $display("FAIL b2b_final_count got=%0d exp=20", wr_count); end
    n_cmp++; if (s_count !== 4'd15) begin n_fail++; $display("FAIL b2b_sat_final got=%0d exp=15", s_count); end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) rf_model[k] = 8'd0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_same_addr();
    test_bypass();
    test_reset_midflight();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
